write_fifo: RTL

Write-side counterpart of the FIFO read engine. Accepts a length-bounded burst of lines from an internal producer stream and writes them into an on-chip FIFO/BRAM write port. A small skid buffer absorbs the producer's almostfull reaction slack. Completion is signalled with a one-cycle op_done pulse.

---
 rtl/write_fifo_if.sv | 22 ++
 rtl/write_fifo.sv | 107 ++++++++++
 2 files changed

// File: rtl/write_fifo_if.sv
// Producer-stream and FIFO write-port signals of the write engine.
// The slave side sits on the engine; master is the surrounding environment.
interface write_fifo_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  in_wvalid;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  in_almostfull;
  logic                  fifo_we;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  fifo_full;

  modport master (
    output in_wvalid, in_wdata, fifo_full,
    input  in_almostfull, fifo_we, fifo_wdata
  );

  modport slave (
    input  in_wvalid, in_wdata, fifo_full,
    output in_almostfull, fifo_we, fifo_wdata
  );
endinterface

// File: rtl/write_fifo.sv
// Length-bounded burst writer: producer beats pass through a small skid
// buffer into a FIFO write port; op_done pulses with the final write.
module write_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int SKID_DEPTH = 8,
  parameter int SLACK      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic [31:0]        configreg,
  output logic               op_done,
  output logic               drop_error,
  write_fifo_if.slave        wif
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(SKID_DEPTH);
  localparam logic [PW:0] AF_LVL   = (PW+1)'(SKID_DEPTH - SLACK);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                r_state;
  logic [15:0]           r_len, r_acc_cnt, r_wr_cnt;
  logic [DATA_WIDTH-1:0] r_skid [SKID_DEPTH];
  logic [PW:0]           r_wptr, r_rptr;
  logic                  r_op_done, r_drop_error, r_we, r_af;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [PW:0] w_occ, w_occ_nxt;
  logic        w_empty, w_full, w_push, w_pop, w_drop, w_last;
  logic        w_in_write_nxt, w_af_nxt;
  logic        w_unused_cfg;

  assign w_unused_cfg = ^configreg[15:0];

  assign w_occ   = r_wptr - r_rptr;
  assign w_empty = (w_occ == '0);
  assign w_full  = (w_occ == FULL_LVL);
  assign w_pop   = !w_empty && !wif.fifo_full;
  // A push into a full skid is still legal when the same edge pops the head.
  assign w_push  = (r_state == WRITE) && wif.in_wvalid &&
                   (r_acc_cnt != r_len) && (!w_full || w_pop);
  assign w_drop  = wif.in_wvalid && !w_push;
  assign w_last  = (r_state == WRITE) && w_pop && ((r_wr_cnt + 16'd1) == r_len);

  assign w_occ_nxt = w_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_in_write_nxt = (r_state == WRITE) ? !w_last
                                             : (op_start && (configreg[31:16] != 16'd0));
  assign w_af_nxt = (w_occ_nxt >= AF_LVL) || (wif.fifo_full && w_in_write_nxt);

  always_ff @(posedge clk) begin
    if (w_push) r_skid[r_wptr[PW-1:0]] <= wif.in_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_acc_cnt    <= '0;
      r_wr_cnt     <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_op_done    <= 1'b0;
      r_drop_error <= 1'b0;
      r_we         <= 1'b0;
      r_af         <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_op_done <= 1'b0;
      r_af      <= w_af_nxt;
      r_we      <= w_pop;
      if (w_push) begin
        r_wptr    <= r_wptr + ONE;
        r_acc_cnt <= r_acc_cnt + 16'd1;
      end
      if (w_pop) begin
        r_wdata  <= r_skid[r_rptr[PW-1:0]];
        r_rptr   <= r_rptr + ONE;
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      case (r_state)
        IDLE: if (op_start) begin
          r_len        <= configreg[31:16];
          r_acc_cnt    <= '0;
          r_wr_cnt     <= '0;
          r_drop_error <= 1'b0;
          if (configreg[31:16] == 16'd0) r_op_done <= 1'b1;
          else                           r_state   <= WRITE;
        end
        WRITE: if (w_last) begin
          r_op_done <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Placed after the start clear so a beat coinciding with op_start still flags.
      if (w_drop) r_drop_error <= 1'b1;
    end
  end

  assign op_done           = r_op_done;
  assign drop_error        = r_drop_error;
  assign wif.fifo_we       = r_we;
  assign wif.fifo_wdata    = r_wdata;
  assign wif.in_almostfull = r_af;
endmodule
